ejector_sink: RTL

EJECTOR_SINK -- requirements
Module: ejector_sink

---
 rtl/ejector_sink.sv | 139 +++++++++++++
 1 files changed

// File: rtl/ejector_sink.sv
// Network ejection sink: grants one router packet per request, buffers it, and drains to the PE.
// Optional per-capture logging is enabled with macro EJECTOR_LOG_EN.
module ejector_sink #(
   parameter int         dataWidth   = 32,
   parameter logic [5:0] ModuleID    = 6'b000_000,
   parameter int         FIFO_DEPTH  = 4,
   parameter int         DRAIN_DELAY = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 ReqUpStr,
   input  logic [dataWidth-1:0] PacketIn,
   output logic                 GntUpStr,
   output logic                 UpStrFull,
   output logic [dataWidth-1:0] PktOut,
   output logic                 PktValid,
   output logic [15:0]          RxCount,
   output logic [7:0]           ErrCount
);

   localparam int            PW      = $clog2(FIFO_DEPTH);
   localparam int            CW      = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
   localparam logic [15:0]   DD_C    = 16'(DRAIN_DELAY);

   typedef enum logic {IDLE = 1'b0, WAIT_REL = 1'b1} state_e;

   state_e               state_q, state_d;
   logic [PW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [15:0]          tmr_q, tmr_d;
   logic [31:0]          cyc_q, cyc_d;
   logic                 gnt_q, gnt_d, vld_q, vld_d;
   logic [dataWidth-1:0] out_q, out_d;
   logic [15:0]          rx_cnt_q, rx_cnt_d;
   logic [7:0]           err_cnt_q, err_cnt_d;
   logic [dataWidth-1:0] mem_q [FIFO_DEPTH];
   logic                 push_s, pop_s, misroute_s;

   // A nonzero residual offset in the low three bits of xDst or yDst means the packet landed at the wrong node.
   assign misroute_s = (PacketIn[30:28] != 3'b000) || (PacketIn[26:24] != 3'b000);

   always_comb begin
      state_d = state_q;
      push_s  = 1'b0;
      case (state_q)
         IDLE: begin
            if (ReqUpStr && (cnt_q < DEPTH_C)) begin
               push_s  = 1'b1;
               state_d = WAIT_REL;
            end else begin
               state_d = IDLE;
            end
         end
         WAIT_REL: begin
            if (!ReqUpStr) begin
               state_d = IDLE;
            end else begin
               state_d = WAIT_REL;
            end
         end
         default: state_d = IDLE;
      endcase
      gnt_d = push_s;
   end

   always_comb begin
      pop_s    = (cnt_q != {CW{1'b0}}) && (tmr_q == DD_C);
      wr_ptr_d = push_s ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop_s ? rd_ptr_q + 1'b1 : rd_ptr_q;
      case ({push_s, pop_s})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
      if ((cnt_q == {CW{1'b0}}) || pop_s) begin
         tmr_d = 16'd0;
      end else begin
         tmr_d = tmr_q + 16'd1;
      end
      out_d     = pop_s ? mem_q[rd_ptr_q] : out_q;
      vld_d     = pop_s;
      rx_cnt_d  = (push_s && (rx_cnt_q != 16'hFFFF)) ? rx_cnt_q + 16'd1 : rx_cnt_q;
      err_cnt_d = (push_s && misroute_s && (err_cnt_q != 8'hFF)) ? err_cnt_q + 8'd1 : err_cnt_q;
      cyc_d     = cyc_q + 32'd1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         wr_ptr_q  <= {PW{1'b0}};
         rd_ptr_q  <= {PW{1'b0}};
         cnt_q     <= {CW{1'b0}};
         tmr_q     <= 16'd0;
         cyc_q     <= 32'd0;
         gnt_q     <= 1'b0;
         vld_q     <= 1'b0;
         out_q     <= {dataWidth{1'b0}};
         rx_cnt_q  <= 16'd0;
         err_cnt_q <= 8'd0;
      end else begin
         state_q   <= state_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         cnt_q     <= cnt_d;
         tmr_q     <= tmr_d;
         cyc_q     <= cyc_d;
         gnt_q     <= gnt_d;
         vld_q     <= vld_d;
         out_q     <= out_d;
         rx_cnt_q  <= rx_cnt_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   // Storage needs no reset: pointers and count define which entries are live.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_q[wr_ptr_q] <= PacketIn;
      end
   end

   assign GntUpStr  = gnt_q;
   assign UpStrFull = (cnt_q == DEPTH_C);
   assign PktOut    = out_q;
   assign PktValid  = vld_q;
   assign RxCount   = rx_cnt_q;
   assign ErrCount  = err_cnt_q;

`ifdef EJECTOR_LOG_EN
   always @(posedge clk) begin
      if (reset && push_s) begin
         $display("Ejector_Log_%0d: %0t %0d xSrc=%0d ySrc=%0d id=%0d misroute=%0b", ModuleID, $time, cyc_q,
                  PacketIn[23:20], PacketIn[19:16], PacketIn[15:6], misroute_s);
      end
   end
`endif

endmodule
